mp1000_mem_upload: RTL and testbench
====================================

MP1000_MEM_UPLOAD -- requirements
Module: mp1000_mem_upload

Interface
REQ-001 SHALL have parameter INDEX, default 8'd0: ioctl_index value served by this block.
REQ-002 SHALL have parameter BASE, default 16'h4000: memory address mapped to ioctl_addr 0.
REQ-003 SHALL have parameter LEN, default 17'd4096: number of bytes served; valid range 1..65536.
REQ-004 SHALL have port clk_sys, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ioctl_upload, input, 1: HPS upload session active.
REQ-007 SHALL have port ioctl_index, input, 8: upload target selector.
REQ-008 SHALL have port ioctl_rd, input, 1: single-cycle byte read strobe from HPS.
REQ-009 SHALL have port ioctl_addr, input, 25: byte offset of the read.
REQ-010 SHALL have port ioctl_din, output, 8: read data returned to HPS.
REQ-011 SHALL have port ioctl_wait, output, 1: HPS stall; high while a read is outstanding.
REQ-012 SHALL have port mem_req, output, 1: request for the shared RAM read port.
REQ-013 SHALL have port mem_addr, output, 16: RAM read address.
REQ-014 SHALL have port mem_gnt, input, 1: arbiter grant; RAM samples mem_addr on a cycle with mem_req and mem_gnt both high.
REQ-015 SHALL have port mem_q, input, 8: RAM data, valid exactly one cycle after the grant cycle.
REQ-016 SHALL have port overrun, output, 1: sticky error flag.

Function
REQ-017 A session SHALL be active only while ioctl_upload=1 and ioctl_index=INDEX; all ioctl_rd outside a session SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, REQ, DATA, DONE.
REQ-019 IDLE: on ioctl_rd in a session, latch ioctl_addr; in the same cycle assert ioctl_wait and go to REQ.
REQ-020 If the latched offset is >= LEN, the block SHALL skip memory, load ioctl_din=8'hFF and go to DONE.
REQ-021 REQ: mem_req=1, mem_addr=BASE+offset[15:0] (mod 2^16 wrap); hold both stable until mem_gnt=1, then go to DATA.
REQ-022 DATA: capture mem_q into ioctl_din; go to DONE.
REQ-023 DONE: ioctl_wait=0; return to IDLE next cycle.
REQ-024 With zero-wait grant, ioctl_wait SHALL be high for exactly 3 cycles (REQ, DATA, DONE-entry) and ioctl_din SHALL be valid on the cycle ioctl_wait falls.
REQ-025 ioctl_din SHALL hold its value until the next completed read.
REQ-026 An ioctl_rd arriving in REQ or DATA SHALL be dropped and SHALL set overrun; an ioctl_rd in DONE SHALL be accepted as in IDLE.
REQ-027 overrun SHALL clear only on reset or on a new session start (rising edge of session-active).
REQ-028 If the session drops in REQ or DATA, the block SHALL go to IDLE next cycle, with mem_req=0 and ioctl_wait=0, and leave ioctl_din unchanged.
REQ-029 mem_req SHALL never be high outside REQ; the block SHALL never write memory.

Reset
REQ-030 While reset_n=0: state IDLE, ioctl_din=8'h00, ioctl_wait=0, mem_req=0, mem_addr=16'h0000, overrun=0, latched offset 0.
REQ-031 Reset deassertion SHALL be synchronised internally; the first read SHALL be accepted no earlier than the second clock after release.

Structure
REQ-032 FSM state enum and the 8'hFF fill constant SHALL live in shared package mp1000_pkg.
REQ-033 The block SHALL be flat; no sub-module.

Verification
REQ-034 BASE=4000h, RAM[4005h]=A5h, grant always 1, read offset 5 -> mem_addr=4005h, ioctl_wait high 3 cycles, ioctl_din=A5h.
REQ-035 Grant held low for 4 cycles -> mem_addr stable throughout, ioctl_wait high 7 cycles, correct data.
REQ-036 LEN=4096, read offset 4096 -> no mem_req, ioctl_din=FFh, ioctl_wait high 2 cycles.
REQ-037 Second ioctl_rd while in REQ -> overrun=1, first read completes correctly; new session -> overrun=0.
REQ-038 ioctl_upload dropped in REQ -> next cycle IDLE, mem_req=0, ioctl_wait=0; reset_n pulsed mid-read -> all outputs at REQ-030 values immediately.
REQ-039 ioctl_index != INDEX with ioctl_rd -> no mem_req and no ioctl_wait.

Source files
------------

// File: rtl/mp1000_pkg.sv
// Shared definitions for the MP1000 upload helpers.
//   state_e   : read-sequencer states
//   FILL_BYTE : byte returned for offsets outside the served window
package mp1000_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/mp1000_mem_upload.sv
// Serves HPS upload reads (ioctl_*) from a shared RAM read port.
// Each accepted ioctl_rd fetches one byte at BASE + offset via a
// req/gnt handshake and returns it on ioctl_din while ioctl_wait stalls HPS.
//
// Ports:
//   clk_sys, reset_n           : clock, async active-low reset
//   ioctl_upload, ioctl_index  : session qualifiers
//   ioctl_rd, ioctl_addr       : read strobe and byte offset
//   ioctl_din, ioctl_wait      : returned byte, HPS stall
//   mem_req, mem_addr, mem_gnt : RAM read-port request / address / grant
//   mem_q                      : RAM data, one cycle after the grant cycle
//   overrun                    : sticky, a read arrived while one was in flight
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for ioctl_rd in an active session
// REQ     | requesting RAM (or filling 8'hFF if offset out of range)
// DATA    | RAM data valid on mem_q, captured into ioctl_din
// DONE    | read complete, ioctl_wait low; a new read may be accepted
module mp1000_mem_upload
  import mp1000_pkg::*;
#(
  parameter logic [7:0]  INDEX = 8'd0,
  parameter logic [15:0] BASE  = 16'h4000,
  parameter logic [16:0] LEN   = 17'd4096
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_q,
  output logic        overrun
);

  localparam logic [24:0] LEN_EXT = {8'd0, LEN};

  state_e      state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [24:0] offset_q, offset_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  din_q, din_d;
  logic        overrun_q, overrun_d;
  logic        session_q, session_d;

  logic session;
  logic rd_ok;
  logic in_range;
  logic wait_c;
  logic req_c;

  assign session  = ioctl_upload && (ioctl_index == INDEX);
  // Reads are ignored until the released reset has passed through the synchroniser.
  assign rd_ok    = ioctl_rd && session && rst_sync_q[1];
  assign in_range = offset_q < LEN_EXT;

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    overrun_d  = overrun_q;
    session_d  = session;
    rst_sync_d = {rst_sync_q[0], 1'b1};
    wait_c     = 1'b0;
    req_c      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (rd_ok) begin
          offset_d   = ioctl_addr;
          mem_addr_d = BASE + ioctl_addr[15:0];
          wait_c     = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_c = 1'b1;
        if (!session) begin
          state_d = ST_IDLE;
        end else if (!in_range) begin
          din_d   = FILL_BYTE;
          state_d = ST_DONE;
        end else begin
          req_c = 1'b1;
          if (mem_gnt) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        wait_c = 1'b1;
        if (!session) begin
          state_d = ST_IDLE;
        end else begin
          din_d   = mem_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_REQ || state_q == ST_DATA) && ioctl_rd && session)
      overrun_d = 1'b1;
    // A fresh session start wins over a simultaneous overrun.
    if (session && !session_q)
      overrun_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
      state_q    <= ST_IDLE;
      offset_q   <= '0;
      mem_addr_q <= '0;
      din_q      <= '0;
      overrun_q  <= 1'b0;
      session_q  <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      state_q    <= state_d;
      offset_q   <= offset_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      overrun_q  <= overrun_d;
      session_q  <= session_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_c;
  assign mem_req    = req_c;
  assign mem_addr   = mem_addr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mp1000_mem_upload.sv
module tb_mp1000_mem_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_q;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  mp1000_mem_upload #(.INDEX(8'd0), .BASE(16'h4000), .LEN(17'd4096)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_q(mem_q), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] ram_model(input logic [15:0] a);
    if (a == 16'h4005) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM data is valid only in the cycle after a grant; zero otherwise.
  always @(posedge clk_sys)
    mem_q <= (mem_req && mem_gnt) ? ram_model(mem_addr) : 8'h00;

  task automatic do_read(input logic [24:0] a, input int gnt_delay,
                         input logic [15:0] exp_addr,
                         output int wait_cnt, output int req_cnt,
                         output logic addr_bad, output logic [7:0] din_fall,
                         output logic timed_out);
    int   cyc;
    logic done;
    wait_cnt = 0; req_cnt = 0; addr_bad = 1'b0; done = 1'b0; cyc = 0;
    din_fall = 8'h00;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    while (!done && cyc < 40) begin
      mem_gnt = (cyc > gnt_delay);
      #1;
      if (ioctl_wait) wait_cnt++;
      else if (cyc > 0) begin
        done     = 1'b1;
        din_fall = ioctl_din;
      end
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== exp_addr) addr_bad = 1'b1;
      end
      if (!done) begin
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
      end
      cyc++;
    end
    ioctl_rd  = 1'b0;
    mem_gnt   = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd0;
    ioctl_rd = 1'b1; ioctl_addr = 25'd5; mem_gnt = 1'b1;
    repeat (3) @(negedge clk_sys);
    #1;
    tests++; if (ioctl_din !== 8'h00) begin fails++; $display("FAIL reset_din got %h exp 00", ioctl_din); end
    tests++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL reset_wait got %b exp 0", ioctl_wait); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", mem_req); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    // Read held across the first clock after release must not be accepted.
    @(negedge clk_sys);
    reset_n = 1'b1;
    #1;
    tests++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL sync_wait0 got %b exp 0", ioctl_wait); end
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) begin
      fails++; $display("FAIL sync_accept got req=%b wait=%b exp 0/0", mem_req, ioctl_wait);
    end
    mem_gnt = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_basic();
    int wc, rc; logic ab, to; logic [7:0] d;
    do_read(25'd5, 0, 16'h4005, wc, rc, ab, d, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout got timeout exp done"); end
    tests++; if (wc != 3) begin fails++; $display("FAIL basic_wait got %0d exp 3", wc); end
    tests++; if (rc != 1 || ab) begin fails++; $display("FAIL basic_req got cnt=%0d bad=%b exp 1/0", rc, ab); end
    tests++; if (d !== 8'hA5) begin fails++; $display("FAIL basic_din got %h exp a5", d); end
    do_read(25'hFFF, 0, 16'h4FFF, wc, rc, ab, d, to);
    tests++; if (to || wc != 3 || d !== ram_model(16'h4FFF) || ab) begin
      fails++; $display("FAIL last_byte got wait=%0d din=%h bad=%b exp 3/%h/0", wc, d, ab, ram_model(16'h4FFF));
    end
  endtask

  task automatic test_grant_delay();
    int wc, rc; logic ab, to; logic [7:0] d;
    do_read(25'h123, 4, 16'h4123, wc, rc, ab, d, to);
    tests++; if (to) begin fails++; $display("FAIL gnt_timeout got timeout exp done"); end
    tests++; if (wc != 7) begin fails++; $display("FAIL gnt_wait got %0d exp 7", wc); end
    tests++; if (rc != 5 || ab) begin fails++; $display("FAIL gnt_req got cnt=%0d bad=%b exp 5/0", rc, ab); end
    tests++; if (d !== ram_model(16'h4123)) begin fails++; $display("FAIL gnt_din got %h exp %h", d, ram_model(16'h4123)); end
  endtask

  task automatic test_out_of_range();
    int wc, rc; logic ab, to; logic [7:0] d;
    do_read(25'd4096, 0, 16'h5000, wc, rc, ab, d, to);
    tests++; if (to || wc != 2) begin fails++; $display("FAIL oor_wait got %0d exp 2", wc); end
    tests++; if (rc != 0) begin fails++; $display("FAIL oor_req got %0d exp 0", rc); end
    tests++; if (d !== 8'hFF) begin fails++; $display("FAIL oor_din got %h exp ff", d); end
    do_read(25'd7, 0, 16'h4007, wc, rc, ab, d, to);
    do_read(25'h1000005, 0, 16'h4005, wc, rc, ab, d, to);
    tests++; if (to || rc != 0 || d !== 8'hFF) begin
      fails++; $display("FAIL oor_high got req=%0d din=%h exp 0/ff", rc, d);
    end
  endtask

  task automatic test_hold();
    repeat (5) @(negedge clk_sys);
    #1;
    tests++; if (ioctl_din !== 8'hFF) begin fails++; $display("FAIL hold_din got %h exp ff", ioctl_din); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_sys);
    mem_gnt = 1'b1; ioctl_addr = 25'd1; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    ioctl_addr = 25'd2; ioctl_rd = 1'b1;
    #1;
    tests++; if (ioctl_wait !== 1'b1 || ioctl_din !== ram_model(16'h4001)) begin
      fails++; $display("FAIL b2b_first got wait=%b din=%h exp 1/%h", ioctl_wait, ioctl_din, ram_model(16'h4001));
    end
    @(negedge clk_sys); ioctl_rd = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h4002) begin
      fails++; $display("FAIL b2b_req got req=%b addr=%h exp 1/4002", mem_req, mem_addr);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    #1;
    tests++; if (ioctl_wait !== 1'b0 || ioctl_din !== ram_model(16'h4002)) begin
      fails++; $display("FAIL b2b_second got wait=%b din=%h exp 0/%h", ioctl_wait, ioctl_din, ram_model(16'h4002));
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_overrun();
    @(negedge clk_sys);
    mem_gnt = 1'b0; ioctl_addr = 25'd7; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'd9; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0; mem_gnt = 1'b1;
    #1;
    tests++; if (overrun !== 1'b1 || mem_addr !== 16'h4007) begin
      fails++; $display("FAIL ovr_set got ovr=%b addr=%h exp 1/4007", overrun, mem_addr);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    mem_gnt = 1'b0;
    #1;
    tests++; if (ioctl_wait !== 1'b0 || ioctl_din !== ram_model(16'h4007)) begin
      fails++; $display("FAIL ovr_first got wait=%b din=%h exp 0/%h", ioctl_wait, ioctl_din, ram_model(16'h4007));
    end
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
    #1;
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    #1;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", overrun); end
  endtask

  task automatic test_abort();
    @(negedge clk_sys);
    mem_gnt = 1'b0; ioctl_addr = 25'h10; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    #1;
    tests++; if (ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL abort_idle got wait=%b req=%b exp 0/0", ioctl_wait, mem_req);
    end
    tests++; if (ioctl_din !== ram_model(16'h4007)) begin
      fails++; $display("FAIL abort_din got %h exp %h", ioctl_din, ram_model(16'h4007));
    end
    @(negedge clk_sys);
    #1;
    tests++; if (ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL abort_stay got wait=%b req=%b exp 0/0", ioctl_wait, mem_req);
    end
  endtask

  task automatic test_wrong_index();
    int wc, rc; logic ab, to; logic [7:0] d;
    ioctl_index = 8'd1;
    do_read(25'd3, 0, 16'h4003, wc, rc, ab, d, to);
    tests++; if (to || wc != 0 || rc != 0) begin
      fails++; $display("FAIL wrong_index got wait=%0d req=%0d exp 0/0", wc, rc);
    end
    ioctl_index = 8'd0; ioctl_upload = 1'b0;
    do_read(25'd3, 0, 16'h4003, wc, rc, ab, d, to);
    tests++; if (to || wc != 0 || rc != 0) begin
      fails++; $display("FAIL no_upload got wait=%0d req=%0d exp 0/0", wc, rc);
    end
    ioctl_upload = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys);
    mem_gnt = 1'b0; ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    #1;
    tests++; if (overrun !== 1'b1 || mem_req !== 1'b1) begin
      fails++; $display("FAIL rmid_pre got ovr=%b req=%b exp 1/1", overrun, mem_req);
    end
    reset_n = 1'b0;
    #1;
    tests++; if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || mem_req !== 1'b0 ||
                 mem_addr !== 16'h0000 || overrun !== 1'b0) begin
      fails++; $display("FAIL rmid_outs got din=%h wait=%b req=%b addr=%h ovr=%b exp 00/0/0/0000/0",
                        ioctl_din, ioctl_wait, mem_req, mem_addr, overrun);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    ioctl_rd = 1'b0; ioctl_addr = '0; mem_gnt = 1'b0;
    ioctl_upload = 1'b0; ioctl_index = 8'd0; reset_n = 1'b0;
    test_reset();
    test_basic();
    test_grant_delay();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_wrong_index();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
